// File: rtl/conv_rd_master.sv
// AXI4 read master: fetches one IFM/WGT tile in 4 KB-safe INCR bursts and
// streams the beats straight into the conv engine buffer slave port.
module conv_rd_master #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int XFER_BYTES      = 46080,
  parameter int BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [63:0]           addr_base,
  input  logic [63:0]           addr_offset,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  axis_tvalid,
  input  logic                  axis_tready,
  output logic [DATA_WIDTH-1:0] axis_tdata
);

  // state | meaning
  // IDLE  | waiting for a rising edge on req
  // RUN   | issuing ARs and forwarding R beats
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int BEATS = XFER_BYTES / 64;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_V = CW'(BEATS);
  localparam logic [3:0]    MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t                state, state_nxt;
  logic                  req_d;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [CW-1:0]         ar_beats, ar_beats_nxt;
  logic [CW-1:0]         r_beats;
  logic [3:0]            outstanding, outst_nxt;

  logic                  start, run, ar_hs, r_hs, r_last_hs;
  logic [8:0]            len_cur;
  logic [ADDR_WIDTH-1:0] addr_sum, start_addr;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [CW-1:0]         iss_beats;
  logic [3:0]            iss_outst;
  logic [8:0]            iss_len;
  logic                  can_issue;

  // Burst length limited by remaining beats, BURST_LEN and the 4 KB page edge.
  function automatic logic [8:0] burst_len(input logic [5:0] page_beat, input logic [CW-1:0] beats);
    logic [31:0] to_4k;
    logic [31:0] lim;
    to_4k = 32'd64 - {26'd0, page_beat};
    lim   = 32'(BURST_LEN);
    if (to_4k < lim) lim = to_4k;
    if (32'(beats) < lim) lim = 32'(beats);
    return lim[8:0];
  endfunction

  assign m_arsize   = 3'b110;
  assign m_arburst  = 2'b01;
  assign axis_tdata = m_rdata;

  assign run        = (state == RUN);
  assign start      = req & ~req_d & (state == IDLE);
  assign ar_hs      = m_arvalid & m_arready;
  assign r_hs       = m_rvalid & m_rready;
  assign r_last_hs  = r_hs & m_rlast;
  assign len_cur    = {1'b0, m_arlen} + 9'd1;
  assign addr_sum   = ADDR_WIDTH'(addr_base + addr_offset);
  assign start_addr = addr_sum & {{(ADDR_WIDTH-6){1'b1}}, 6'b0};

  always_comb begin
    cur_addr_nxt = cur_addr;
    ar_beats_nxt = ar_beats;
    outst_nxt    = outstanding;
    if (ar_hs) begin
      cur_addr_nxt = cur_addr + ADDR_WIDTH'({len_cur, 6'b0});
      ar_beats_nxt = ar_beats - CW'(len_cur);
    end
    case ({ar_hs, r_last_hs})
      2'b10:   outst_nxt = outstanding + 4'd1;
      2'b01:   outst_nxt = outstanding - 4'd1;
      default: outst_nxt = outstanding;
    endcase
  end

  // Next AR is evaluated against post-handshake values so bursts can go back to back.
  always_comb begin
    iss_addr  = start ? start_addr : cur_addr_nxt;
    iss_beats = start ? BEATS_V : ar_beats_nxt;
    iss_outst = start ? 4'd0 : outst_nxt;
    iss_len   = burst_len(iss_addr[11:6], iss_beats);
    can_issue = (start | (run & (~m_arvalid | m_arready))) &
                (iss_beats != '0) & (iss_outst < MAX_OUT);
  end

  always_comb begin
    state_nxt   = state;
    done        = 1'b0;
    busy        = (state != IDLE);
    m_rready    = axis_tready & run;
    axis_tvalid = m_rvalid & run;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (r_hs && r_beats == CW'(1)) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_d       <= 1'b0;
      cur_addr    <= '0;
      ar_beats    <= '0;
      r_beats     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      m_arvalid   <= 1'b0;
      m_araddr    <= '0;
      m_arlen     <= '0;
    end else begin
      state <= state_nxt;
      req_d <= req;
      if (start) begin
        cur_addr    <= start_addr;
        ar_beats    <= BEATS_V;
        r_beats     <= BEATS_V;
        outstanding <= '0;
        err         <= 1'b0;
      end else if (run) begin
        cur_addr    <= cur_addr_nxt;
        ar_beats    <= ar_beats_nxt;
        outstanding <= outst_nxt;
        if (r_hs) begin
          r_beats <= r_beats - CW'(1);
          if (m_rresp != 2'b00) err <= 1'b1;
        end
      end
      if (can_issue) begin
        m_arvalid <= 1'b1;
        m_araddr  <= iss_addr;
        m_arlen   <= 8'(iss_len - 9'd1);
      end else if (ar_hs) begin
        m_arvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_rd_master.sv
// Scoreboard bench for conv_rd_master: memory-slave model, expected AR/data
// queues built from the tiling rules, and a negedge monitor that checks them.
module tb_conv_rd_master;

  localparam int NBEATS = 720;
  localparam int MAXO   = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [63:0]  addr_base, addr_offset;
  logic         done, busy, err;
  logic         m_arvalid, m_arready;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_rvalid, m_rready;
  logic [511:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         axis_tvalid, axis_tready;
  logic [511:0] axis_tdata;

  conv_rd_master dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_base(addr_base), .addr_offset(addr_offset),
    .done(done), .busy(busy), .err(err),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] addr; int len; } burst_t;

  ar_t          ar_exp_q[$];
  logic [511:0] dat_exp_q[$];

  int checks = 0;
  int errors = 0;

  // slave knobs
  bit          r_en = 1'b1;
  bit          ar_rand = 1'b0;
  bit          tr_rand = 1'b0;
  logic [63:0] err_addr = '1;

  // monitor statistics
  int cyc = 0, beat_cnt = 0, done_cnt = 0, ar_cnt = 0, last_beat_cyc = -10, out_model = 0;
  logic err_at_done = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = a + 64'(i) * 64'h1000_0000_0000_0001;
    return d;
  endfunction

  // AXI memory slave: in-order bursts, data derived from beat address.
  initial begin : slave
    burst_t bq[$];
    int     bidx;
    bit     arhs, rhs;
    logic [63:0] a;
    bidx = 0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      arhs = m_arvalid & m_arready;
      rhs  = m_rvalid & m_rready;
      if (arhs) bq.push_back('{m_araddr, int'(m_arlen) + 1});
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bq.delete();
        bidx = 0;
      end else if (rhs && bq.size() > 0) begin
        bidx++;
        if (bidx == bq[0].len) begin
          void'(bq.pop_front());
          bidx = 0;
        end
      end
      m_arready   = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_en && bq.size() > 0) begin
        a        = bq[0].addr + 64'(bidx) * 64;
        m_rvalid = 1'b1;
        m_rdata  = mk_data(a);
        m_rlast  = (bidx == bq[0].len - 1);
        m_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
      end
    end
  end

  // Monitor: pops expected ARs/beats on handshakes, tracks outstanding bursts.
  initial begin : monitor
    int endb;
    ar_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_model = 0;
      end else begin
        if (m_arvalid && m_arready) begin
          ar_cnt++;
          chk("outstanding_limit", 512'(out_model < MAXO), 512'(1));
          endb = int'(m_araddr[11:0]) + (int'(m_arlen) + 1) * 64;
          chk("ar_no_4k_cross", 512'(endb <= 4096), 512'(1));
          chk("ar_expected", 512'(ar_exp_q.size() != 0), 512'(1));
          if (ar_exp_q.size() != 0) begin
            e = ar_exp_q.pop_front();
            chk("araddr", 512'(m_araddr), 512'(e.addr));
            chk("arlen", 512'(m_arlen), 512'(e.len));
          end
          out_model++;
        end
        if (axis_tvalid && axis_tready) begin
          beat_cnt++;
          last_beat_cyc = cyc;
          chk("beat_expected", 512'(dat_exp_q.size() != 0), 512'(1));
          if (dat_exp_q.size() != 0) chk("tdata", axis_tdata, dat_exp_q.pop_front());
          if (m_rlast) out_model--;
        end
        if (done) begin
          chk("done_latency", 512'(cyc), 512'(last_beat_cyc + 1));
          done_cnt++;
          err_at_done = err;
        end
        chk("rready_mirror", 512'(m_rready), 512'(axis_tready & busy & ~done));
        chk("tvalid_mirror", 512'(axis_tvalid), 512'(m_rvalid & busy & ~done));
      end
      cyc++;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_done"}, 512'(done), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_err"}, 512'(err), 512'(0));
    chk({tag, "_arvalid"}, 512'(m_arvalid), 512'(0));
    chk({tag, "_rready"}, 512'(m_rready), 512'(0));
    chk({tag, "_tvalid"}, 512'(axis_tvalid), 512'(0));
    chk({tag, "_araddr"}, 512'(m_araddr), 512'(0));
    chk({tag, "_arlen"}, 512'(m_arlen), 512'(0));
  endtask

  task automatic run_xfer(input logic [63:0] base, input logic [63:0] off,
                          input int hold_r, input int abort_at);
    logic [63:0] a, sa;
    int rem, len, pg, d0, b0, a0, t;
    bit exp_err;
    sa = (base + off) & ~64'h3f;
    a = sa; rem = NBEATS; exp_err = 1'b0;
    while (rem > 0) begin
      len = rem;
      if (len > 64) len = 64;
      pg = (4096 - int'(a[11:0])) / 64;
      if (pg < len) len = pg;
      ar_exp_q.push_back('{a, 8'(len - 1)});
      for (int i = 0; i < len; i++) begin
        if (a + 64'(i) * 64 == err_addr) exp_err = 1'b1;
        dat_exp_q.push_back(mk_data(a + 64'(i) * 64));
      end
      a = a + 64'(len) * 64;
      rem -= len;
    end
    d0 = done_cnt; b0 = beat_cnt; a0 = ar_cnt;
    addr_base = base; addr_offset = off;
    r_en = (hold_r == 0);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_arvalid", 512'(m_arvalid), 512'(1));
    chk("start_busy", 512'(busy), 512'(1));
    chk("start_err_clear", 512'(err), 512'(0));
    if (hold_r > 0) begin
      repeat (hold_r) @(negedge clk);
      chk("ar_limit_count", 512'(ar_cnt - a0), 512'(MAXO));
      chk("ar_limit_idle", 512'(m_arvalid), 512'(0));
      r_en = 1'b1;
    end
    if (abort_at > 0) begin
      t = 0;
      while (beat_cnt - b0 < abort_at && t < 20000) begin @(negedge clk); t++; end
      chk("abort_reach_timeout", 512'(beat_cnt - b0 >= abort_at), 512'(1));
      @(posedge clk); #2 rst_n = 1'b0;
      #1 chk_outputs_zero("async_rst");
      repeat (3) @(negedge clk);
      chk("abort_no_done", 512'(done_cnt - d0), 512'(0));
      ar_exp_q.delete(); dat_exp_q.delete();
      req = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
    chk("done_timeout", 512'(done_cnt != d0), 512'(1));
    repeat (3) @(negedge clk);
    chk("beat_total", 512'(beat_cnt - b0), 512'(NBEATS));
    chk("done_once", 512'(done_cnt - d0), 512'(1));
    chk("ar_all_seen", 512'(ar_exp_q.size()), 512'(0));
    chk("data_all_seen", 512'(dat_exp_q.size()), 512'(0));
    chk("err_at_done", 512'(err_at_done), 512'(exp_err));
    chk("err_sticky", 512'(err), 512'(exp_err));
    chk("idle_after", 512'(busy), 512'(0));
    ar_exp_q.delete(); dat_exp_q.delete();
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr_base = '0; addr_offset = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("arsize", 512'(m_arsize), 512'(3'b110));
    chk("arburst", 512'(m_arburst), 512'(2'b01));
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(64'h1000_0000, 64'h0, 0, 0);          // aligned tile
    ar_rand = 1'b1;
    run_xfer(64'h2000_0F80, 64'h0, 0, 0);          // 4 KB crossing, random arready
    ar_rand = 1'b0;
    run_xfer(64'h3000_0000, 64'h40, 50, 0);        // outstanding limit
    tr_rand = 1'b1;
    run_xfer(64'h4000_0800, 64'h23, 0, 0);         // backpressure, unaligned offset
    tr_rand = 1'b0;
    err_addr = 64'h5000_0000 + 64'd100 * 64;
    run_xfer(64'h5000_0000, 64'h0, 0, 0);          // error response on beat 100
    err_addr = '1;
    run_xfer(64'h6000_0000, 64'h0, 0, 300);        // reset mid-transfer
    chk_outputs_zero("post_rst");
    tr_rand = 1'b1; ar_rand = 1'b1;
    run_xfer(64'h7000_0FC0, 64'h0, 0, 0);          // fresh transfer after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
